// File: rtl/pixel_sweep_scheduler.sv
// Round-robin owner arbitration for a single full-frame pixel sweep engine.
// Walks x/y plus a running linear address, one write strobe per accepted pixel.
module pixel_sweep_scheduler #(
  parameter int H_PIXELS = 160,
  parameter int V_PIXELS = 120,
  parameter int XBITS    = 8,
  parameter int YBITS    = 7,
  parameter int ABITS    = 15
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [2:0]       req,
  input  logic             stall,
  output logic [2:0]       grant,
  output logic             busy,
  output logic [XBITS-1:0] x,
  output logic [YBITS-1:0] y,
  output logic [ABITS-1:0] addr,
  output logic             wren,
  output logic             done,
  output logic [1:0]       done_id
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] SWEEP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] gidx;
  logic [1:0] pick;
  logic       any_req;
  logic       granted_req;
  logic       last_pix;
  logic       x_wrap;

  assign any_req     = |req;
  assign granted_req = |(req & grant);
  assign x_wrap      = (x == XBITS'(H_PIXELS - 1));
  assign last_pix    = x_wrap && (y == YBITS'(V_PIXELS - 1));

  assign busy    = (state != IDLE);
  assign wren    = (state == SWEEP) && !stall;
  assign done    = (state == DONE);
  assign done_id = done ? gidx : 2'd0;

  // Search starts one past the last served index and wraps.
  always_comb begin
    pick = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      grant <= 3'b000;
      gidx  <= 2'd0;
      last  <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= GRANT;
            grant <= 3'b001 << pick;
            gidx  <= pick;
          end
        end
        GRANT: begin
          if (!granted_req) begin
            state <= IDLE;
            grant <= 3'b000;
            last  <= gidx;
          end else begin
            state <= SWEEP;
          end
        end
        SWEEP: begin
          // A dropped request wins over completion: the owner gave up the frame.
          if (!granted_req) begin
            state <= IDLE;
            grant <= 3'b000;
            last  <= gidx;
          end else if (!stall && last_pix) begin
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 3'b000;
          last  <= gidx;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (state == SWEEP) begin
      if (wren && !last_pix) begin
        if (x_wrap) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
        addr <= addr + 1'b1;
      end
    end else begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end
  end

endmodule
